// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
//
// Issue controller for the E-stage multiply/divide unit of the pipelined MIPS
// CPU. Decodes the E-stage MDU operation and emits the start pulse and op
// code. Times a running mult/div with its own countdown. Generates the
// D-stage stall for HI/LO-class instructions. Suppresses issue when CP0
// cancels the E-stage instruction.
//
// Ports:
//   clk           rising-edge system clock
//   reset         synchronous, active-low
//   e_valid       E-stage holds a real (non-bubble) instruction
//   e_mdu_op      E-stage op: 000 mult, 001 multu, 010 div, 011 divu,
//                 100 mthi, 101 mtlo, 110 nop/other
//   cancel        exception/interrupt kills the E-stage instruction
//   d_is_mdu      D-stage instruction is a HI/LO-class instruction
//   mdu_start     one-cycle start pulse to the MDU (combinational)
//   mdu_op        op to the MDU; 110 unless something is issuing
//   hilo_we       mthi/mtlo commit strobe (combinational)
//   busy          high while a mult/div is running (registered state)
//   stall_d       freeze PC/D and bubble E
//   remain        cycles left in the current operation, 0 when idle
//   proto_err     sticky: an MDU op reached E while an operation was running
//   stall_cycles  free-running count of stalled cycles, wraps at 2^32
// ---------------------------------------------------------------------------
module mdu_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [2:0]       e_mdu_op,
    input  logic             cancel,
    input  logic             d_is_mdu,
    output logic             mdu_start,
    output logic [2:0]       mdu_op,
    output logic             hilo_we,
    output logic             busy,
    output logic             stall_d,
    output logic [CNT_W-1:0] remain,
    output logic             proto_err,
    output logic [31:0]      stall_cycles
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic               proto_err_q, proto_err_d;
    logic [31:0]        stall_cycles_q, stall_cycles_d;

    logic issue;
    logic op_is_muldiv;
    logic op_is_mt;

    // Ops 000..011 all have bit 2 clear; bit 1 separates div from mult.
    assign op_is_muldiv = (e_mdu_op[2] == 1'b0);
    assign op_is_mt     = (e_mdu_op == OP_MTHI) || (e_mdu_op == OP_MTLO);

    // Nothing issues while reset is held, so the combinational outputs
    // reflect the cleared state during reset as well.
    assign issue = reset && e_valid && !cancel && (state_q == IDLE);

    always_comb begin
        state_d        = state_q;
        remain_d       = remain_q;
        proto_err_d    = proto_err_q;
        stall_cycles_d = stall_cycles_q;
        mdu_start      = 1'b0;
        hilo_we        = 1'b0;
        mdu_op         = OP_NOP;

        case (state_q)
            IDLE: begin
                if (issue && op_is_muldiv) begin
                    mdu_start = 1'b1;
                    mdu_op    = e_mdu_op;
                    state_d   = RUN;
                    remain_d  = e_mdu_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end else if (issue && op_is_mt) begin
                    hilo_we = 1'b1;
                    mdu_op  = e_mdu_op;
                end
            end
            RUN: begin
                // An op in E while running means the D-stage stall was not
                // honoured; it is dropped and flagged. cancel is irrelevant
                // here: an issued mult/div always runs to completion.
                if (e_valid && (e_mdu_op != OP_NOP)) begin
                    proto_err_d = 1'b1;
                end
                if (remain_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    remain_d = '0;
                end else begin
                    remain_d = remain_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                remain_d = '0;
            end
        endcase

        // Stall in the issue cycle too, so a dependent mfhi/mflo cannot
        // enter E alongside the start.
        stall_d        = d_is_mdu && ((state_q == RUN) || mdu_start);
        stall_cycles_d = stall_cycles_q + 32'(stall_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            remain_q       <= '0;
            proto_err_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            remain_q       <= remain_d;
            proto_err_q    <= proto_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign busy         = (state_q == RUN);
    assign remain       = remain_q;
    assign proto_err    = proto_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_issue_ctrl
//
// Directed bench for mdu_issue_ctrl with default parameters (MULT_LAT=5,
// DIV_LAT=10). Inputs change 1 time unit after a rising edge; outputs are
// sampled 1 time unit after that (combinational) or 1 time unit after the
// edge (registered). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [2:0]  e_mdu_op;
    logic        cancel;
    logic        d_is_mdu;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic        hilo_we;
    logic        busy;
    logic        stall_d;
    logic [3:0]  remain;
    logic        proto_err;
    logic [31:0] stall_cycles;

    int tests_run = 0;
    int tests_failed = 0;

    mdu_issue_ctrl #(
        .MULT_LAT(5),
        .DIV_LAT (10),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .e_valid     (e_valid),
        .e_mdu_op    (e_mdu_op),
        .cancel      (cancel),
        .d_is_mdu    (d_is_mdu),
        .mdu_start   (mdu_start),
        .mdu_op      (mdu_op),
        .hilo_we     (hilo_we),
        .busy        (busy),
        .stall_d     (stall_d),
        .remain      (remain),
        .proto_err   (proto_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        e_valid  = 1'b1;
        e_mdu_op = 3'b000;
        cancel   = 1'b0;
        d_is_mdu = 1'b0;

        // Reset held for 3 edges with a mult presented in E.
        tick(); tick(); tick();
        #1;
        chk("rst_start", {31'd0, mdu_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_remain", {28'd0, remain}, 32'd0);
        chk("rst_stallcnt", stall_cycles, 32'd0);
        chk("rst_proto", {31'd0, proto_err}, 32'd0);
        chk("rst_op", {29'd0, mdu_op}, 32'd6);

        reset    = 1'b1;
        e_valid  = 1'b0;
        e_mdu_op = 3'b110;
        tick();

        // mult at T with a dependent instruction in D throughout.
        e_valid  = 1'b1;
        e_mdu_op = 3'b000;
        d_is_mdu = 1'b1;
        #1;
        chk("mul_start_T", {31'd0, mdu_start}, 32'd1);
        chk("mul_op_T", {29'd0, mdu_op}, 32'd0);
        chk("mul_stall_T", {31'd0, stall_d}, 32'd1);
        chk("mul_hilo_T", {31'd0, hilo_we}, 32'd0);
        tick();
        e_valid  = 1'b0;
        e_mdu_op = 3'b110;
        #1;
        chk("mul_busy_T1", {31'd0, busy}, 32'd1);
        chk("mul_remain_T1", {28'd0, remain}, 32'd5);
        chk("mul_start_T1", {31'd0, mdu_start}, 32'd0);
        chk("mul_stall_T1", {31'd0, stall_d}, 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("mul_remain", {28'd0, remain}, 32'(5 - i));
            chk("mul_busy", {31'd0, busy}, (i < 5) ? 32'd1 : 32'd0);
        end
        #1;
        chk("mul_stall_T6", {31'd0, stall_d}, 32'd0);
        chk("mul_stallcnt", stall_cycles, 32'd6);

        // divu, with a cancel arriving mid-run.
        d_is_mdu = 1'b0;
        e_valid  = 1'b1;
        e_mdu_op = 3'b011;
        #1;
        chk("div_start_T", {31'd0, mdu_start}, 32'd1);
        chk("div_op_T", {29'd0, mdu_op}, 32'd3);
        tick();
        e_valid  = 1'b0;
        e_mdu_op = 3'b110;
        for (int i = 1; i <= 10; i++) begin
            cancel = (i == 3);
            #1;
            chk("div_busy", {31'd0, busy}, 32'd1);
            chk("div_remain", {28'd0, remain}, 32'(11 - i));
            tick();
        end
        cancel = 1'b0;
        chk("div_busy_T11", {31'd0, busy}, 32'd0);
        chk("div_remain_T11", {28'd0, remain}, 32'd0);

        // Back-to-back mult issues at T+11.
        e_valid  = 1'b1;
        e_mdu_op = 3'b000;
        #1;
        chk("b2b_start", {31'd0, mdu_start}, 32'd1);
        chk("b2b_op", {29'd0, mdu_op}, 32'd0);
        tick();
        // multu presented while running: ignored and flagged.
        e_mdu_op = 3'b001;
        #1;
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("viol_start", {31'd0, mdu_start}, 32'd0);
        chk("viol_hilo", {31'd0, hilo_we}, 32'd0);
        chk("viol_op", {29'd0, mdu_op}, 32'd6);
        chk("viol_proto_pre", {31'd0, proto_err}, 32'd0);
        tick();
        e_valid  = 1'b0;
        e_mdu_op = 3'b110;
        chk("viol_proto", {31'd0, proto_err}, 32'd1);
        chk("viol_remain", {28'd0, remain}, 32'd4);
        tick();
        chk("viol_sticky", {31'd0, proto_err}, 32'd1);
        chk("viol_stallcnt", stall_cycles, 32'd6);

        // Reset mid-run.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_remain", {28'd0, remain}, 32'd0);
        chk("mrst_proto", {31'd0, proto_err}, 32'd0);

        // Cancel at IDLE suppresses a div.
        cancel   = 1'b1;
        e_valid  = 1'b1;
        e_mdu_op = 3'b010;
        #1;
        chk("cancel_start", {31'd0, mdu_start}, 32'd0);
        chk("cancel_op", {29'd0, mdu_op}, 32'd6);
        tick();
        chk("cancel_busy", {31'd0, busy}, 32'd0);

        // mthi then mtlo on consecutive cycles, dependent instruction in D.
        cancel   = 1'b0;
        d_is_mdu = 1'b1;
        e_mdu_op = 3'b100;
        #1;
        chk("mthi_we", {31'd0, hilo_we}, 32'd1);
        chk("mthi_op", {29'd0, mdu_op}, 32'd4);
        chk("mthi_start", {31'd0, mdu_start}, 32'd0);
        chk("mthi_stall", {31'd0, stall_d}, 32'd0);
        tick();
        e_mdu_op = 3'b101;
        #1;
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_we", {31'd0, hilo_we}, 32'd1);
        chk("mtlo_op", {29'd0, mdu_op}, 32'd5);
        chk("mtlo_stall", {31'd0, stall_d}, 32'd0);
        tick();
        e_valid  = 1'b0;
        e_mdu_op = 3'b110;
        chk("mt_busy", {31'd0, busy}, 32'd0);
        chk("mt_stallcnt", stall_cycles, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
